// File: rtl/alu_4_checker_if.sv
// ALU sweep bus: start request and operands in, ALU select/operands out, ALU result back, sweep status out.
// master is the checker side; slave is the ALU/host side.
interface alu_4_checker_if;
   logic       Start;
   logic [3:0] A_in;
   logic [3:0] B_in;
   logic       S2;
   logic       S1;
   logic       S0;
   logic       Cin;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] G;
   logic       Cout;
   logic       Busy;
   logic       Done;
   logic       Pass;
   logic [4:0] ErrCount;
   logic       FailValid;
   logic [3:0] FailCode;

   modport master (
      input  Start, A_in, B_in, G, Cout,
      output S2, S1, S0, Cin, A, B, Busy, Done, Pass, ErrCount, FailValid, FailCode
   );

   modport slave (
      output Start, A_in, B_in, G, Cout,
      input  S2, S1, S0, Cin, A, B, Busy, Done, Pass, ErrCount, FailValid, FailCode
   );
endinterface

// File: rtl/alu_4_checker.sv
// Sweeps all 16 {S2,S1,S0,Cin} codes into a 4-bit ALU and checks G/Cout against a golden model.
// Sweep takes 16*(SETTLE+2)+1 cycles from Start to Done; Start is ignored while a sweep runs.
module alu_4_checker #(
   parameter int SETTLE = 1
) (
   input  logic            CLK,
   input  logic            RESETn,
   alu_4_checker_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_FIN} state_t;

   state_t     state;
   logic [3:0] idx;
   logic [2:0] wcnt;
   logic [3:0] y;
   logic [3:0] lg;
   logic [4:0] expd;

   // Golden model evaluated on the registered code/operands currently applied to the ALU.
   always_comb begin
      y    = 4'b0000;
      lg   = 4'b0000;
      expd = 5'b00000;
      if (!bus.S2) begin
         case ({bus.S1, bus.S0})
            2'b00: y = 4'b0000;
            2'b01: y = bus.B;
            2'b10: y = ~bus.B;
            2'b11: y = 4'b1111;
         endcase
         expd = {1'b0, bus.A} + {1'b0, y} + {4'b0000, bus.Cin};
      end else begin
         case ({bus.S1, bus.S0})
            2'b00: lg = bus.A & bus.B;
            2'b01: lg = bus.A | bus.B;
            2'b10: lg = bus.A ^ bus.B;
            2'b11: lg = ~bus.A;
         endcase
         expd = {1'b0, lg};
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state         <= S_IDLE;
         idx           <= 4'd0;
         wcnt          <= 3'd0;
         bus.S2        <= 1'b0;
         bus.S1        <= 1'b0;
         bus.S0        <= 1'b0;
         bus.Cin       <= 1'b0;
         bus.A         <= 4'd0;
         bus.B         <= 4'd0;
         bus.Busy      <= 1'b0;
         bus.Done      <= 1'b0;
         bus.Pass      <= 1'b0;
         bus.ErrCount  <= 5'd0;
         bus.FailValid <= 1'b0;
         bus.FailCode  <= 4'd0;
      end else begin
         bus.Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.Start) begin
                  bus.A         <= bus.A_in;
                  bus.B         <= bus.B_in;
                  bus.ErrCount  <= 5'd0;
                  bus.FailValid <= 1'b0;
                  bus.FailCode  <= 4'd0;
                  bus.Pass      <= 1'b0;
                  bus.Busy      <= 1'b1;
                  idx           <= 4'd0;
                  state         <= S_APPLY;
               end
            end
            // The code register updates as APPLY ends, so it is stable SETTLE+1 cycles before sampling.
            S_APPLY: begin
               {bus.S2, bus.S1, bus.S0, bus.Cin} <= idx;
               wcnt  <= 3'd0;
               state <= (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
               if (wcnt == 3'(SETTLE - 1)) state <= S_CHECK;
               else                        wcnt  <= wcnt + 3'd1;
            end
            S_CHECK: begin
               if ({bus.Cout, bus.G} != expd) begin
                  bus.ErrCount <= bus.ErrCount + 5'd1;
                  if (!bus.FailValid) begin
                     bus.FailValid <= 1'b1;
                     bus.FailCode  <= {bus.S2, bus.S1, bus.S0, bus.Cin};
                  end
               end
               if (idx == 4'd15) begin
                  state <= S_FIN;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= S_APPLY;
               end
            end
            S_FIN: begin
               bus.Done <= 1'b1;
               bus.Busy <= 1'b0;
               bus.Pass <= (bus.ErrCount == 5'd0);
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_4_checker.sv
// Directed bench for alu_4_checker: behavioural ALU with injectable faults, two DUTs (SETTLE=1 and SETTLE=0).
module tb_alu_4_checker;

   logic CLK    = 1'b0;
   logic RESETn = 1'b0;
   int   fault0 = 0;
   int   n_assert = 0;
   int   n_fail   = 0;

   alu_4_checker_if bus0 ();
   alu_4_checker_if bus1 ();

   alu_4_checker #(.SETTLE(1)) dut0 (.CLK(CLK), .RESETn(RESETn), .bus(bus0));
   alu_4_checker #(.SETTLE(0)) dut1 (.CLK(CLK), .RESETn(RESETn), .bus(bus1));

   always #5 CLK = ~CLK;

   // Behavioural ALU; fault 1 inverts Cout on logic ops, fault 2 sticks G[0] at 0.
   function automatic logic [4:0] alu_ref(input logic [3:0] code, input logic [3:0] a,
                                          input logic [3:0] b, input int fault);
      int         r;
      logic [4:0] v;
      case (code[3:1])
         3'd0:    r = int'(a) + int'(code[0]);
         3'd1:    r = int'(a) + int'(b) + int'(code[0]);
         3'd2:    r = int'(a) + (15 - int'(b)) + int'(code[0]);
         3'd3:    r = int'(a) + 15 + int'(code[0]);
         3'd4:    r = int'(a & b);
         3'd5:    r = int'(a | b);
         3'd6:    r = int'(a ^ b);
         default: r = 15 - int'(a);
      endcase
      v = r[4:0];
      if (fault == 1 && code[3]) v[4] = ~v[4];
      if (fault == 2) v[0] = 1'b0;
      return v;
   endfunction

   assign {bus0.Cout, bus0.G} = alu_ref({bus0.S2, bus0.S1, bus0.S0, bus0.Cin}, bus0.A, bus0.B, fault0);
   assign {bus1.Cout, bus1.G} = alu_ref({bus1.S2, bus1.S1, bus1.S0, bus1.Cin}, bus1.A, bus1.B, 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs0();
      return {7'd0, bus0.S2, bus0.S1, bus0.S0, bus0.Cin, bus0.A, bus0.B, bus0.Busy, bus0.Done,
              bus0.Pass, bus0.ErrCount, bus0.FailValid, bus0.FailCode};
   endfunction

   function automatic logic [31:0] outs1();
      return {7'd0, bus1.S2, bus1.S1, bus1.S0, bus1.Cin, bus1.A, bus1.B, bus1.Busy, bus1.Done,
              bus1.Pass, bus1.ErrCount, bus1.FailValid, bus1.FailCode};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start0(input logic [3:0] a, input logic [3:0] b);
      bus0.A_in  = a;
      bus0.B_in  = b;
      bus0.Start = 1'b1;
      tick();
      bus0.Start = 1'b0;
   endtask

   // Counts edges after the accepting edge until Done; optional Start pulse/hold at given cycle numbers.
   task automatic wait_done0(input int pulse_at, input int hold_from, input bit chk_codes, output int cyc);
      bit seen1 = 1'b0;
      bit seen2 = 1'b0;
      cyc = 0;
      while (cyc < 200) begin
         tick();
         cyc++;
         if (pulse_at > 0 || hold_from > 0)
            bus0.Start = (cyc == pulse_at) || (hold_from > 0 && cyc >= hold_from);
         if (chk_codes && !seen1 && {bus0.S2, bus0.S1, bus0.S0, bus0.Cin} == 4'b0001) begin
            seen1 = 1'b1;
            check("code0001_result", {27'd0, bus0.Cout, bus0.G}, 32'b10000);
         end
         if (chk_codes && !seen2 && {bus0.S2, bus0.S1, bus0.S0, bus0.Cin} == 4'b0010) begin
            seen2 = 1'b1;
            check("code0010_result", {27'd0, bus0.Cout, bus0.G}, 32'b10000);
         end
         if (bus0.Done) break;
      end
      if (chk_codes) check("codes_seen", {30'd0, seen1, seen2}, 32'b11);
   endtask

   initial begin
      int n;
      int dcnt;
      bus0.Start = 1'b0; bus0.A_in = 4'd0; bus0.B_in = 4'd0;
      bus1.Start = 1'b0; bus1.A_in = 4'd0; bus1.B_in = 4'd0;

      // Reset state
      tick(); tick();
      check("reset_outs0", outs0(), 32'd0);
      check("reset_outs1", outs1(), 32'd0);
      RESETn = 1'b1;
      tick();
      check("idle_busy", {31'd0, bus0.Busy}, 32'd0);

      // Correct ALU, A=1111 B=0001
      fault0 = 0;
      start0(4'hF, 4'h1);
      check("t1_accept", {23'd0, bus0.Busy, bus0.A, bus0.B}, {23'd0, 1'b1, 4'hF, 4'h1});
      wait_done0(0, 0, 1'b1, n);
      check("t1_latency", n, 49);
      check("t1_status", {24'd0, bus0.Pass, bus0.ErrCount, bus0.FailValid, bus0.Busy},
            {24'd0, 1'b1, 5'd0, 1'b0, 1'b0});
      tick();
      check("t1_done_pulse", {30'd0, bus0.Done, bus0.Pass}, 32'b01);

      // Cout inverted on logic ops
      fault0 = 1;
      start0(4'h3, 4'h5);
      wait_done0(0, 0, 1'b0, n);
      check("t2_latency", n, 49);
      check("t2_status", {21'd0, bus0.Pass, bus0.ErrCount, bus0.FailValid, bus0.FailCode},
            {21'd0, 1'b0, 5'd8, 1'b1, 4'b1000});

      // G[0] stuck at 0, zero operands
      fault0 = 2;
      start0(4'h0, 4'h0);
      wait_done0(0, 0, 1'b0, n);
      check("t3_status", {21'd0, bus0.Pass, bus0.ErrCount, bus0.FailValid, bus0.FailCode},
            {21'd0, 1'b0, 5'd6, 1'b1, 4'b0001});
      tick();
      check("t3_hold", {23'd0, bus0.ErrCount, bus0.FailCode}, {23'd0, 5'd6, 4'b0001});

      // Start pulsed mid-sweep is ignored; Start held over FIN chains a second sweep
      fault0 = 0;
      start0(4'h9, 4'h6);
      wait_done0(10, 48, 1'b0, n);
      check("t4_latency_a", n, 49);
      check("t4_pass_a", {31'd0, bus0.Pass}, 32'd1);
      tick();
      bus0.Start = 1'b0;
      check("t4_rearm", {29'd0, bus0.Busy, bus0.Pass, bus0.Done}, 32'b100);
      wait_done0(0, 0, 1'b0, n);
      check("t4_latency_b", n, 49);
      check("t4_pass_b", {31'd0, bus0.Pass}, 32'd1);

      // Reset during the 6th code
      start0(4'h3, 4'hC);
      repeat (16) tick();
      check("t5_code5", {28'd0, bus0.S2, bus0.S1, bus0.S0, bus0.Cin}, 32'd5);
      RESETn = 1'b0;
      #1;
      check("t5_reset_outs", outs0(), 32'd0);
      tick(); tick();
      RESETn = 1'b1;
      dcnt = 0;
      repeat (60) begin
         tick();
         if (bus0.Done) dcnt++;
      end
      check("t5_no_done", dcnt, 0);
      check("t5_idle_busy", {31'd0, bus0.Busy}, 32'd0);
      start0(4'hA, 4'h6);
      wait_done0(0, 0, 1'b0, n);
      check("t5_latency", n, 49);
      check("t5_status", {25'd0, bus0.Pass, bus0.ErrCount, bus0.FailValid},
            {25'd0, 1'b1, 5'd0, 1'b0});

      // SETTLE=0 instance
      bus1.A_in  = 4'h7;
      bus1.B_in  = 4'h9;
      bus1.Start = 1'b1;
      tick();
      bus1.Start = 1'b0;
      check("t6_busy", {31'd0, bus1.Busy}, 32'd1);
      n = 0;
      while (n < 200) begin
         tick();
         n++;
         if (bus1.Done) break;
      end
      check("t6_latency", n, 33);
      check("t6_status", {25'd0, bus1.Pass, bus1.ErrCount, bus1.FailValid},
            {25'd0, 1'b1, 5'd0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
